// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst engine: FSM state encoding,
// bus response codes and the burst sizing helper.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_DONE
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam int         BEAT_BYTES  = 4;
   localparam int         BOUNDARY_4K = 4096;
   localparam int         BEAT_W      = 30;

   // Beats in the next burst: limited by what is left, the burst cap and the
   // words remaining before the next 4 KB page so a burst never crosses it.
   function automatic logic [8:0] burst_beats(input logic [BEAT_W-1:0] beats_left,
                                              input logic [11:0]       addr_lo,
                                              input int                max_burst);
      logic [12:0] to_bound;
      logic [10:0] lim;
      to_bound = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
      lim      = 11'(to_bound / 13'(BEAT_BYTES));
      if (lim > 11'(max_burst)) lim = 11'(max_burst);
      return (beats_left < BEAT_W'(lim)) ? beats_left[8:0] : lim[8:0];
   endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Small synchronous FIFO used to stage GLB read data ahead of the DRAM
// write data channel.
module dma_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dma_burst_engine.sv
// DMA burst engine: moves one tile between DRAM (AXI-style bursts) and the
// GLB SRAM, splitting at 4 KB pages, and pulses done_o on completion.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for start_i
// ST_RD_ADDR | read burst address offered on ar channel
// ST_RD_DATA | read beats written straight into the GLB
// ST_WR_ADDR | write burst address offered on aw channel
// ST_WR_DATA | GLB prefetch into FIFO, FIFO drained onto w channel
// ST_WR_RESP | waiting for the write response of the burst
// ST_DONE    | one-cycle completion pulse
module dma_burst_engine
   import dma_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int GLB_AW     = 14,
   parameter int DATA_W     = 32,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              dir_i,
   input  logic [ADDR_W-1:0] dram_addr_i,
   input  logic [GLB_AW-1:0] glb_addr_i,
   input  logic [31:0]       len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic [7:0]        arlen_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   input  logic              rlast_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic [7:0]        awlen_o,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [3:0]        wstrb_o,
   output logic              wlast_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   input  logic [1:0]        bresp_i,
   input  logic              bvalid_i,
   output logic              bready_o,
   output logic              glb_en_o,
   output logic              glb_we_o,
   output logic [GLB_AW-1:0] glb_addr_o,
   output logic [DATA_W-1:0] glb_wdata_o,
   output logic [3:0]        glb_bweb_o,
   input  logic [DATA_W-1:0] glb_rdata_i
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [GLB_AW-1:0]   glb_addr_q;
   logic [1:0]          last_bytes_q;
   logic [BEAT_W-1:0]   beats_left_q;
   logic [8:0]          burst_left_q;
   logic [8:0]          fetch_left_q;
   logic                rd_pend_q;
   logic                err_q;

   logic [BEAT_W-1:0]   total_beats;
   logic [8:0]          burst_now;
   logic                start_acc, ar_hs, aw_hs, r_hs, w_hs, b_hs;
   logic                final_beat, fetch;
   logic [3:0]          strb_last;
   logic [DATA_W-1:0]   fifo_dout;
   logic                fifo_full, fifo_empty;
   logic [CW-1:0]       fifo_count;

   assign total_beats = BEAT_W'((34'(len_i) + 34'd3) >> 2);
   assign burst_now   = burst_beats(beats_left_q, addr_q[11:0], MAX_BURST);
   assign start_acc   = (state_q == ST_IDLE) && start_i;
   assign ar_hs       = (state_q == ST_RD_ADDR) && arready_i;
   assign aw_hs       = (state_q == ST_WR_ADDR) && awready_i;
   assign r_hs        = (state_q == ST_RD_DATA) && rvalid_i;
   assign w_hs        = wvalid_o && wready_i;
   assign b_hs        = (state_q == ST_WR_RESP) && bvalid_i;
   assign final_beat  = (burst_left_q == 9'd1) && (beats_left_q == '0);
   assign strb_last   = (last_bytes_q == 2'd0) ? 4'hF : 4'((5'd1 << last_bytes_q) - 5'd1);
   // One GLB read is in flight at most, so occupancy plus pending bounds the FIFO.
   assign fetch       = (state_q == ST_WR_DATA) && (fetch_left_q != '0) && !fifo_full &&
                        ((fifo_count + CW'(rd_pend_q)) < CW'(FIFO_DEPTH));

   dma_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_pend_q),
      .din   (glb_rdata_i),
      .pop   (w_hs),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_i) begin
            if (len_i == '0 || dram_addr_i[1:0] != 2'b00) state_d = ST_DONE;
            else if (dir_i)                               state_d = ST_WR_ADDR;
            else                                          state_d = ST_RD_ADDR;
         end
         ST_RD_ADDR: if (arready_i) state_d = ST_RD_DATA;
         ST_RD_DATA: if (rvalid_i && rlast_i)
            state_d = (beats_left_q != '0) ? ST_RD_ADDR : ST_DONE;
         ST_WR_ADDR: if (awready_i) state_d = ST_WR_DATA;
         ST_WR_DATA: if (w_hs && wlast_o) state_d = ST_WR_RESP;
         ST_WR_RESP: if (bvalid_i)
            state_d = (beats_left_q != '0) ? ST_WR_ADDR : ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != ST_IDLE);
      done_o      = (state_q == ST_DONE);
      err_o       = err_q;
      arvalid_o   = (state_q == ST_RD_ADDR);
      araddr_o    = arvalid_o ? addr_q : '0;
      arlen_o     = arvalid_o ? 8'(burst_now - 9'd1) : '0;
      rready_o    = (state_q == ST_RD_DATA);
      awvalid_o   = (state_q == ST_WR_ADDR);
      awaddr_o    = awvalid_o ? addr_q : '0;
      awlen_o     = awvalid_o ? 8'(burst_now - 9'd1) : '0;
      wvalid_o    = (state_q == ST_WR_DATA) && !fifo_empty;
      wdata_o     = wvalid_o ? fifo_dout : '0;
      wlast_o     = wvalid_o && (burst_left_q == 9'd1);
      wstrb_o     = wvalid_o ? (final_beat ? strb_last : 4'hF) : 4'h0;
      bready_o    = (state_q == ST_WR_RESP);
      glb_en_o    = 1'b0;
      glb_we_o    = 1'b0;
      glb_addr_o  = '0;
      glb_wdata_o = '0;
      glb_bweb_o  = 4'h0;
      if (r_hs) begin
         glb_en_o    = 1'b1;
         glb_we_o    = 1'b1;
         glb_addr_o  = glb_addr_q;
         glb_wdata_o = rdata_i;
         glb_bweb_o  = final_beat ? ~strb_last : 4'h0;
      end else if (fetch) begin
         glb_en_o    = 1'b1;
         glb_addr_o  = glb_addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         glb_addr_q   <= '0;
         last_bytes_q <= '0;
         beats_left_q <= '0;
         burst_left_q <= '0;
         fetch_left_q <= '0;
         rd_pend_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         rd_pend_q <= fetch;
         if (start_acc) begin
            addr_q       <= dram_addr_i;
            glb_addr_q   <= glb_addr_i;
            last_bytes_q <= len_i[1:0];
            beats_left_q <= total_beats;
            burst_left_q <= '0;
            fetch_left_q <= '0;
            err_q        <= (dram_addr_i[1:0] != 2'b00);
         end
         if (ar_hs || aw_hs) begin
            beats_left_q <= beats_left_q - BEAT_W'(burst_now);
            addr_q       <= addr_q + ADDR_W'(burst_now) * ADDR_W'(BEAT_BYTES);
            burst_left_q <= burst_now;
            fetch_left_q <= burst_now;
         end
         if (r_hs) begin
            glb_addr_q   <= glb_addr_q + GLB_AW'(1);
            burst_left_q <= burst_left_q - 9'd1;
            if (rresp_i != RESP_OKAY) err_q <= 1'b1;
         end
         if (fetch) begin
            glb_addr_q   <= glb_addr_q + GLB_AW'(1);
            fetch_left_q <= fetch_left_q - 9'd1;
         end
         if (w_hs) burst_left_q <= burst_left_q - 9'd1;
         if (b_hs && bresp_i != RESP_OKAY) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_burst_engine.sv
// Scoreboard bench for dma_burst_engine: directed transfers push expected
// bus/GLB traffic into queues; a monitor pops and compares on each handshake.
module tb_dma_burst_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i, dir_i;
   logic [31:0] dram_addr_i, len_i;
   logic [13:0] glb_addr_i;
   logic        busy_o, done_o, err_o;
   logic [31:0] araddr_o, awaddr_o, rdata_i, wdata_o, glb_wdata_o, glb_rdata_i;
   logic [7:0]  arlen_o, awlen_o;
   logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
   logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
   logic [1:0]  rresp_i, bresp_i;
   logic [3:0]  wstrb_o, glb_bweb_o;
   logic        glb_en_o, glb_we_o;
   logic [13:0] glb_addr_o;

   always #5 clk = ~clk;

   dma_burst_engine dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .dir_i(dir_i),
      .dram_addr_i(dram_addr_i), .glb_addr_i(glb_addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
      .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
      .glb_en_o(glb_en_o), .glb_we_o(glb_we_o), .glb_addr_o(glb_addr_o),
      .glb_wdata_o(glb_wdata_o), .glb_bweb_o(glb_bweb_o), .glb_rdata_i(glb_rdata_i)
   );

   typedef struct { logic [31:0] addr; logic [7:0] len; } addr_t;
   typedef struct { logic [13:0] addr; logic [31:0] data; logic [3:0] bweb; } glbw_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
   typedef struct { logic [31:0] addr; int beats; } rb_t;

   addr_t exp_ar[$], exp_aw[$];
   glbw_t exp_glb[$];
   w_t    exp_w[$];
   logic  exp_done[$];

   int errors = 0, checks = 0;
   int cyc = 0, done_seen = 0, last_done_cyc = 0, last_rlast_cyc = 0;
   int glb_wr_cnt = 0, act_cnt = 0, start_cyc = 0;
   logic stall = 1'b0, rd_timing = 1'b0;
   logic [1:0] bresp_cfg = 2'b00;

   function automatic logic [31:0] dram_word(input logic [31:0] a);
      return 32'h5A00_0000 ^ a;
   endfunction

   function automatic logic [31:0] glb_word(input logic [13:0] a);
      return 32'hC3C3_0000 | {18'b0, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
      addr_t e; e.addr = a; e.len = l; exp_ar.push_back(e);
   endtask
   task automatic push_aw(input logic [31:0] a, input logic [7:0] l);
      addr_t e; e.addr = a; e.len = l; exp_aw.push_back(e);
   endtask
   task automatic push_glbw(input logic [13:0] g, input logic [31:0] d, input logic [3:0] bweb);
      glbw_t e; e.addr = g; e.data = dram_word(d); e.bweb = bweb; exp_glb.push_back(e);
   endtask
   task automatic push_w(input logic [31:0] d, input logic [3:0] s, input logic l);
      w_t e; e.data = d; e.strb = s; e.last = l; exp_w.push_back(e);
   endtask

   // Slave models: DRAM read/write responder and GLB read port.
   rb_t         rd_bursts[$];
   int          r_left = 0, b_pend = 0;
   logic [31:0] r_addr = '0;
   logic        glb_rd_pend = 1'b0;
   logic [13:0] glb_rd_addr = '0;

   initial begin
      arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 0;
      awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0; glb_rdata_i = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rd_bursts.delete(); r_left = 0; b_pend = 0; glb_rd_pend = 0;
         end else begin
            if (arvalid_o && arready_i) begin
               rb_t b; b.addr = araddr_o; b.beats = int'(arlen_o) + 1; rd_bursts.push_back(b);
            end
            if (rvalid_i && rready_o) begin r_left--; r_addr += 32'd4; end
            if (wvalid_o && wready_i && wlast_o) b_pend++;
            if (bvalid_i && bready_o) b_pend--;
            glb_rd_pend = glb_en_o && !glb_we_o;
            glb_rd_addr = glb_addr_o;
         end
         @(posedge clk); #1;
         if (r_left == 0 && rd_bursts.size() > 0) begin
            rb_t b; b = rd_bursts.pop_front(); r_addr = b.addr; r_left = b.beats;
         end
         arready_i   = !stall || ($urandom_range(0, 1) == 1);
         awready_i   = !stall || ($urandom_range(0, 1) == 1);
         wready_i    = !stall || ($urandom_range(0, 2) != 0);
         rvalid_i    = (r_left != 0) && (!stall || $urandom_range(0, 3) != 0);
         rdata_i     = dram_word(r_addr);
         rlast_i     = (r_left == 1);
         bvalid_i    = (b_pend > 0);
         bresp_i     = bresp_cfg;
         glb_rdata_i = glb_rd_pend ? glb_word(glb_rd_addr) : 32'hDEAD_BEEF;
      end
   end

   // Monitor: compares every DUT-presented transaction against the queues.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         if (arvalid_o || awvalid_o || glb_en_o || rready_o || wvalid_o || bready_o) act_cnt++;
         if (arvalid_o && arready_i) begin
            if (exp_ar.size() == 0) chk("unexpected_ar", araddr_o, 64'hFFFF_FFFF_FFFF);
            else begin
               addr_t e; e = exp_ar.pop_front();
               chk("araddr", araddr_o, e.addr);
               chk("arlen", arlen_o, e.len);
            end
         end
         if (rvalid_i && rready_o && rlast_i) last_rlast_cyc = cyc;
         if (glb_en_o && glb_we_o) begin
            glb_wr_cnt++;
            if (exp_glb.size() == 0) chk("unexpected_glb_wr", glb_addr_o, 64'hFFFF_FFFF_FFFF);
            else begin
               glbw_t e; e = exp_glb.pop_front();
               chk("glb_addr", glb_addr_o, e.addr);
               chk("glb_wdata", glb_wdata_o, e.data);
               chk("glb_bweb", glb_bweb_o, e.bweb);
            end
         end
         if (awvalid_o && awready_i) begin
            if (exp_aw.size() == 0) chk("unexpected_aw", awaddr_o, 64'hFFFF_FFFF_FFFF);
            else begin
               addr_t e; e = exp_aw.pop_front();
               chk("awaddr", awaddr_o, e.addr);
               chk("awlen", awlen_o, e.len);
            end
         end
         if (wvalid_o && wready_i) begin
            if (exp_w.size() == 0) chk("unexpected_w", wdata_o, 64'hFFFF_FFFF_FFFF);
            else begin
               w_t e; e = exp_w.pop_front();
               chk("wdata", wdata_o, e.data);
               chk("wstrb", wstrb_o, e.strb);
               chk("wlast", wlast_o, e.last);
            end
         end
         if (done_o) begin
            done_seen++;
            last_done_cyc = cyc;
            if (exp_done.size() == 0) chk("unexpected_done", done_o, 0);
            else chk("done_err", err_o, exp_done.pop_front());
            if (rd_timing) chk("done_after_rlast", cyc - last_rlast_cyc, 1);
         end
      end
   end

   task automatic start_xfer(input logic dir, input logic [31:0] a, input logic [13:0] g,
                             input logic [31:0] len);
      dir_i = dir; dram_addr_i = a; glb_addr_i = g; len_i = len; start_i = 1;
      start_cyc = cyc + 1;
      @(posedge clk); #1;
      start_i = 0;
   endtask

   task automatic finish_xfer(input string name);
      int n;
      n = done_seen;
      for (int k = 0; k < 3000 && done_seen == n; k++) @(posedge clk);
      #1;
      checks++;
      if (done_seen == n) begin
         errors++;
         $display("FAIL %s_done_timeout: got no done expected done", name);
      end
      chk({name, "_busy_after"}, {busy_o, done_o}, 2'b00);
      chk({name, "_drained"}, exp_ar.size() + exp_aw.size() + exp_glb.size() + exp_w.size() +
          exp_done.size(), 0);
   endtask

   initial begin
      int act0, d0;
      rst_n = 0; start_i = 0; dir_i = 0; dram_addr_i = 0; glb_addr_i = 0; len_i = 0;
      #2;
      chk("rst_ctrl", {busy_o, done_o, err_o, arvalid_o, rready_o, awvalid_o, wvalid_o,
                       bready_o, glb_en_o, glb_we_o}, 0);
      chk("rst_fields", {araddr_o, arlen_o, awlen_o, wstrb_o, glb_bweb_o}, 0);
      repeat (3) @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      // Read, single burst; a stray start while busy must be ignored.
      rd_timing = 1; stall = 0;
      push_ar(32'h1000, 8'd9);
      for (int i = 0; i < 10; i++) push_glbw(14'(i), 32'h1000 + 32'(4 * i), 4'b0000);
      exp_done.push_back(1'b0);
      start_xfer(1'b0, 32'h1000, 14'h0, 32'd40);
      repeat (2) @(posedge clk); #1;
      chk("busy_mid", busy_o, 1);
      start_xfer(1'b1, 32'h9000, 14'h55, 32'd8);
      finish_xfer("rd40");

      // Read, two bursts with partial final word, stalls on.
      stall = 1;
      push_ar(32'h2000, 8'd15);
      push_ar(32'h2040, 8'd1);
      for (int i = 0; i < 18; i++)
         push_glbw(14'h100 + 14'(i), 32'h2000 + 32'(4 * i), (i == 17) ? 4'b1100 : 4'b0000);
      exp_done.push_back(1'b0);
      start_xfer(1'b0, 32'h2000, 14'h100, 32'd70);
      finish_xfer("rd70");

      // Read split at 4 KB boundary, GLB address wraps.
      push_ar(32'h0FF8, 8'd1);
      push_ar(32'h1000, 8'd5);
      for (int i = 0; i < 8; i++)
         push_glbw(14'h3FFE + 14'(i), 32'h0FF8 + 32'(4 * i), 4'b0000);
      exp_done.push_back(1'b0);
      start_xfer(1'b0, 32'h0FF8, 14'h3FFE, 32'd32);
      finish_xfer("rd4k");

      // Write, len 6 with stalls.
      rd_timing = 0;
      push_aw(32'h3000, 8'd1);
      push_w(glb_word(14'h20), 4'hF, 1'b0);
      push_w(glb_word(14'h21), 4'b0011, 1'b1);
      exp_done.push_back(1'b0);
      start_xfer(1'b1, 32'h3000, 14'h20, 32'd6);
      finish_xfer("wr6");

      // Write, 25 beats across a 4 KB boundary.
      push_aw(32'h4FC0, 8'd15);
      push_aw(32'h5000, 8'd8);
      for (int i = 0; i < 25; i++)
         push_w(glb_word(14'h200 + 14'(i)), 4'hF, (i == 15) || (i == 24));
      exp_done.push_back(1'b0);
      start_xfer(1'b1, 32'h4FC0, 14'h200, 32'd100);
      finish_xfer("wr100");

      // Misaligned address: error, no activity, sticky err.
      stall = 0;
      act0 = act_cnt;
      exp_done.push_back(1'b1);
      start_xfer(1'b0, 32'h1002, 14'h0, 32'd16);
      finish_xfer("misalign");
      chk("misalign_quiet", act_cnt - act0, 0);
      repeat (2) @(posedge clk); #1;
      chk("err_sticky", err_o, 1);

      // Zero length: done without activity, err cleared.
      act0 = act_cnt;
      exp_done.push_back(1'b0);
      start_xfer(1'b0, 32'h1000, 14'h0, 32'd0);
      finish_xfer("len0");
      chk("len0_quiet", act_cnt - act0, 0);
      chk("len0_latency", (last_done_cyc - start_cyc) inside {[1:2]}, 1);

      // Write response error.
      bresp_cfg = 2'b10;
      push_aw(32'h6000, 8'd1);
      push_w(glb_word(14'h40), 4'hF, 1'b0);
      push_w(glb_word(14'h41), 4'hF, 1'b1);
      exp_done.push_back(1'b1);
      start_xfer(1'b1, 32'h6000, 14'h40, 32'd8);
      finish_xfer("bresp");
      bresp_cfg = 2'b00;

      // Reset in the middle of a read burst.
      push_ar(32'h7000, 8'd15);
      for (int i = 0; i < 16; i++) push_glbw(14'(i), 32'h7000 + 32'(4 * i), 4'b0000);
      d0 = glb_wr_cnt;
      start_xfer(1'b0, 32'h7000, 14'h0, 32'd64);
      for (int k = 0; k < 200 && glb_wr_cnt < d0 + 3; k++) @(posedge clk);
      chk("rst_wait_beats", glb_wr_cnt >= d0 + 3, 1);
      #2 rst_n = 0;
      #1;
      chk("midrst_ctrl", {busy_o, done_o, err_o, arvalid_o, rready_o, awvalid_o, wvalid_o,
                          bready_o, glb_en_o, glb_we_o}, 0);
      exp_ar.delete(); exp_glb.delete();
      d0 = done_seen;
      repeat (3) @(posedge clk); #1;
      rst_n = 1;
      repeat (3) @(posedge clk); #1;
      chk("no_done_after_reset", done_seen, d0);

      // Normal read after reset.
      rd_timing = 1;
      push_ar(32'h8000, 8'd1);
      push_glbw(14'h10, 32'h8000, 4'b0000);
      push_glbw(14'h11, 32'h8004, 4'b0000);
      exp_done.push_back(1'b0);
      start_xfer(1'b0, 32'h8000, 14'h10, 32'd8);
      finish_xfer("rd_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
